plab5_mcore_mem_req_serializer: RTL

//  Converts one full memory request message {type,opaque,addr,len,data} into a flit

---
 rtl/plab5_mcore_mem_req_serializer_pkg.sv | 51 +++++
 rtl/plab5_mcore_MemReqCMsgPack.sv | 19 +
 rtl/plab5_mcore_mem_req_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/plab5_mcore_mem_req_serializer_pkg.sv
// Shared definitions for the memory-request serializer: message type codes,
// FSM state encoding, flit-kind markers and field/flit width helpers.
package plab5_mcore_mem_req_serializer_pkg;

    localparam int unsigned MSG_TYPE_NBITS = 3;

    typedef enum logic [MSG_TYPE_NBITS-1:0] {
        MSG_TYPE_READ    = 3'd0,
        MSG_TYPE_WRITE   = 3'd1,
        MSG_TYPE_INIT    = 3'd2,
        MSG_TYPE_AMO_ADD = 3'd3,
        MSG_TYPE_AMO_AND = 3'd4,
        MSG_TYPE_AMO_OR  = 3'd5
    } mem_req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } ser_state_e;

    // Value of the flit-kind bit (the MSB of every flit)
    localparam logic FLIT_HDR  = 1'b1;
    localparam logic FLIT_DATA = 1'b0;

    // len encodes a byte count in [0, d/8); 0 means full width
    function automatic int unsigned mem_req_len_nbits(input int unsigned d);
        return $clog2(d / 8);
    endfunction

    function automatic int unsigned mem_req_msg_nbits(input int unsigned o,
                                                      input int unsigned a,
                                                      input int unsigned d);
        return MSG_TYPE_NBITS + o + a + mem_req_len_nbits(d) + d;
    endfunction

    // Control-only width c: the full message minus its data field
    function automatic int unsigned mem_req_cmsg_nbits(input int unsigned o,
                                                       input int unsigned a,
                                                       input int unsigned d);
        return mem_req_msg_nbits(o, a, d) - d;
    endfunction

    // Flit = kind bit + c payload bits; kind bit sits at index c
    function automatic int unsigned mem_req_flit_nbits(input int unsigned o,
                                                       input int unsigned a,
                                                       input int unsigned d);
        return mem_req_cmsg_nbits(o, a, d) + 1;
    endfunction

endpackage

// File: rtl/plab5_mcore_MemReqCMsgPack.sv
// Packs the control fields of a memory request into the header payload
// {type, opaque, addr, len}.
module plab5_mcore_MemReqCMsgPack
    import plab5_mcore_mem_req_serializer_pkg::*;
#(
    parameter int unsigned p_opaque_nbits = 8,
    parameter int unsigned p_addr_nbits   = 32,
    parameter int unsigned p_len_nbits    = 2
) (
    input  logic [MSG_TYPE_NBITS-1:0]                                    msg_type,
    input  logic [p_opaque_nbits-1:0]                                    opaque,
    input  logic [p_addr_nbits-1:0]                                      addr,
    input  logic [p_len_nbits-1:0]                                       len,
    output logic [MSG_TYPE_NBITS+p_opaque_nbits+p_addr_nbits+p_len_nbits-1:0] msg
);

    assign msg = {msg_type, opaque, addr, len};

endmodule

// File: rtl/plab5_mcore_mem_req_serializer.sv
// Serializes a full memory request into a header flit plus (non-READ) data flit.
// Define PLAB5_MCORE_MEM_REQ_SER_PIPE_EN to accept the next request on the last flit.
module plab5_mcore_mem_req_serializer
    import plab5_mcore_mem_req_serializer_pkg::*;
#(
    parameter  int unsigned p_opaque_nbits = 8,
    parameter  int unsigned p_addr_nbits   = 32,
    parameter  int unsigned p_data_nbits   = 32,
    localparam int unsigned MsgNbits  = mem_req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int unsigned FlitNbits = mem_req_flit_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [MsgNbits-1:0]  in_msg,
    input  logic                 in_val,
    output logic                 in_rdy,
    output logic [FlitNbits-1:0] out_msg,
    output logic                 out_val,
    input  logic                 out_rdy
);

    localparam int unsigned LenNbits  = mem_req_len_nbits(p_data_nbits);
    localparam int unsigned CNbits    = mem_req_cmsg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits);
    localparam int unsigned PadNbits  = CNbits - p_data_nbits;
    localparam int unsigned LenLsb    = p_data_nbits;
    localparam int unsigned AddrLsb   = LenLsb + LenNbits;
    localparam int unsigned OpaqueLsb = AddrLsb + p_addr_nbits;
    localparam int unsigned TypeLsb   = OpaqueLsb + p_opaque_nbits;

    ser_state_e          state_q, state_d;
    logic [MsgNbits-1:0] msg_q, msg_d;
    logic                in_rdy_q, in_rdy_d;
    logic                out_val_q, out_val_d;

    logic [MSG_TYPE_NBITS-1:0] fld_type;
    logic [p_opaque_nbits-1:0] fld_opaque;
    logic [p_addr_nbits-1:0]   fld_addr;
    logic [LenNbits-1:0]       fld_len;
    logic [p_data_nbits-1:0]   fld_data;
    logic [CNbits-1:0]         cmsg;

    logic is_read;
    logic out_fire;
    logic last_flit;
    logic in_fire;

    // Field split of the captured request
    assign fld_data   = msg_q[p_data_nbits-1:0];
    assign fld_len    = msg_q[LenLsb    +: LenNbits];
    assign fld_addr   = msg_q[AddrLsb   +: p_addr_nbits];
    assign fld_opaque = msg_q[OpaqueLsb +: p_opaque_nbits];
    assign fld_type   = msg_q[TypeLsb   +: MSG_TYPE_NBITS];

    plab5_mcore_MemReqCMsgPack #(
        .p_opaque_nbits (p_opaque_nbits),
        .p_addr_nbits   (p_addr_nbits),
        .p_len_nbits    (LenNbits)
    ) u_cmsg_pack (
        .msg_type (fld_type),
        .opaque   (fld_opaque),
        .addr     (fld_addr),
        .len      (fld_len),
        .msg      (cmsg)
    );

    assign is_read   = (fld_type == MSG_TYPE_READ);
    assign out_fire  = out_val_q & out_rdy;
    assign last_flit = (state_q == ST_DATA) | ((state_q == ST_HDR) & is_read);

`ifdef PLAB5_MCORE_MEM_REQ_SER_PIPE_EN
    // Reopen for the next request in the same cycle the final flit leaves
    assign in_rdy = ~reset & (in_rdy_q | (out_fire & last_flit));
`else
    assign in_rdy = in_rdy_q;
`endif

    assign in_fire = in_val & in_rdy;
    assign out_val = out_val_q;
    assign out_msg = (state_q == ST_HDR) ? {FLIT_HDR, cmsg}
                                         : {FLIT_DATA, {PadNbits{1'b0}}, fld_data};

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;

        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_HDR:  if (out_fire) state_d = is_read ? ST_IDLE : ST_DATA;
            ST_DATA: if (out_fire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // A captured request always starts with its header, whatever state it arrives in
        if (in_fire) begin
            msg_d   = in_msg;
            state_d = ST_HDR;
        end

        in_rdy_d  = (state_d == ST_IDLE);
        out_val_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            msg_q     <= '0;
            in_rdy_q  <= 1'b0;
            out_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            in_rdy_q  <= in_rdy_d;
            out_val_q <= out_val_d;
        end
    end

endmodule
